// File: rtl/word_serializer16.sv
// 16-bit parallel-to-serial converter: valid/ready word intake, each bit held
// for HOLD enabled cycles, and ENABLE=0 freezes every piece of state.
module word_serializer16 #(
  parameter int MSB_FIRST = 1,
  parameter int HOLD      = 1
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] IN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        ENABLE,
  output logic        SOUT,
  output logic        SOUT_VALID,
  output logic [3:0]  BIT_IDX,
  output logic        FIRST,
  output logic        LAST,
  output logic        BUSY
);

  localparam int            HW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);
  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    SHIFT    = 1'b1;

  logic [0:0]    state_reg;
  logic [15:0]   word_reg;
  logic [3:0]    count_reg;
  logic [HW-1:0] hold_reg;

  logic       shifting;
  logic       hold_last;
  logic       word_done;
  logic       xfer;
  logic [3:0] idx;

  assign shifting  = (state_reg == SHIFT);
  assign hold_last = (hold_reg == HOLD_MAX);
  assign word_done = shifting && (count_reg == 4'd15) && hold_last;

  // Ready during the final hold cycle lets the next word follow with no bubble.
  assign IN_READY  = ENABLE && (!shifting || word_done);
  assign xfer      = IN_VALID && IN_READY;
  assign idx       = (MSB_FIRST != 0) ? ~count_reg : count_reg;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_reg <= IDLE;
      word_reg  <= 16'd0;
      count_reg <= 4'd0;
      hold_reg  <= '0;
    end else if (ENABLE) begin
      if (xfer) begin
        state_reg <= SHIFT;
        word_reg  <= IN;
        count_reg <= 4'd0;
        hold_reg  <= '0;
      end else if (shifting) begin
        if (hold_last) begin
          // count wraps 15 -> 0 on its own as the word completes
          hold_reg  <= '0;
          count_reg <= count_reg + 4'd1;
          if (count_reg == 4'd15) begin
            state_reg <= IDLE;
          end
        end else begin
          hold_reg <= hold_reg + 1'b1;
        end
      end
    end
  end

  // Outputs decode straight from frozen state, so they hold during a pause.
  assign BUSY       = shifting;
  assign SOUT_VALID = shifting && ENABLE;
  assign BIT_IDX    = shifting ? idx : 4'd0;
  assign SOUT       = shifting && word_reg[idx];
  assign FIRST      = SOUT_VALID && (count_reg == 4'd0);
  assign LAST       = SOUT_VALID && (count_reg == 4'd15);

endmodule

// File: tb/tb_word_serializer16.sv
// Scoreboard bench for word_serializer16: instance A (MSB first, HOLD=1) and
// instance B (LSB first, HOLD=3) share clock and reset.
module tb_word_serializer16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] in_a, in_b;
  logic        in_valid_a, in_valid_b, enable_a, enable_b;
  logic        in_ready_a, sout_a, sout_valid_a, first_a, last_a, busy_a;
  logic        in_ready_b, sout_b, sout_valid_b, first_b, last_b, busy_b;
  logic [3:0]  bit_idx_a, bit_idx_b;

  word_serializer16 #(.MSB_FIRST(1), .HOLD(1)) dut_a (
    .CLK(clk), .nRESET(rst_n), .IN(in_a), .IN_VALID(in_valid_a), .IN_READY(in_ready_a),
    .ENABLE(enable_a), .SOUT(sout_a), .SOUT_VALID(sout_valid_a), .BIT_IDX(bit_idx_a),
    .FIRST(first_a), .LAST(last_a), .BUSY(busy_a)
  );

  word_serializer16 #(.MSB_FIRST(0), .HOLD(3)) dut_b (
    .CLK(clk), .nRESET(rst_n), .IN(in_b), .IN_VALID(in_valid_b), .IN_READY(in_ready_b),
    .ENABLE(enable_b), .SOUT(sout_b), .SOUT_VALID(sout_valid_b), .BIT_IDX(bit_idx_b),
    .FIRST(first_b), .LAST(last_b), .BUSY(busy_b)
  );

  typedef struct packed {
    logic       sout;
    logic [3:0] idx;
    logic       first;
    logic       last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   tests = 0;
  int   fails = 0;

  // Instance A: MSB first, one cycle per bit.
  function automatic void push_a(input logic [15:0] w);
    for (int i = 0; i < 16; i++)
      q_a.push_back('{sout: w[15-i], idx: 4'(15 - i), first: (i == 0), last: (i == 15)});
  endfunction

  // Instance B: LSB first, three cycles per bit.
  function automatic void push_b(input logic [15:0] w);
    for (int i = 0; i < 16; i++)
      for (int h = 0; h < 3; h++)
        q_b.push_back('{sout: w[i], idx: 4'(i), first: (i == 0), last: (i == 15)});
  endfunction

  task automatic test_reset();
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_valid_a = 1'b1; in_valid_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({sout_a, sout_valid_a, first_a, last_a, busy_a, bit_idx_a} !== 9'd0) begin
        fails++;
        $display("FAIL reset_outputs_a: got %b, want 000000000", {sout_a, sout_valid_a, first_a, last_a, busy_a, bit_idx_a});
      end
      tests++;
      if ({sout_b, sout_valid_b, first_b, last_b, busy_b, bit_idx_b} !== 9'd0) begin
        fails++;
        $display("FAIL reset_outputs_b: got %b, want 000000000", {sout_b, sout_valid_b, first_b, last_b, busy_b, bit_idx_b});
      end
    end
    enable_a = 1'b0;
    #1;
    tests++;
    if (in_ready_a !== 1'b0) begin
      fails++;
      $display("FAIL idle_disabled_ready: got %b, want 0", in_ready_a);
    end
    enable_a = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy_a, in_ready_a, busy_b, in_ready_b} !== 4'b0101) begin
      fails++;
      $display("FAIL reset_release_idle: got busy/ready a,b=%b, want 0101", {busy_a, in_ready_a, busy_b, in_ready_b});
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_msb_hold1();
    exp_t e;
    int nvalid = 0;
    bit sent = 0;
    logic [15:0] seen = 16'd0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (sout_valid_a) begin
        nvalid++;
        seen = {seen[14:0], sout_a};
        tests++;
        if (q_a.size() == 0) begin
          fails++;
          $display("FAIL msb_sb: unexpected bit sout=%b idx=%0d, want none", sout_a, bit_idx_a);
        end else begin
          e = q_a.pop_front();
          if ({sout_a, bit_idx_a, first_a, last_a} !== e) begin
            fails++;
            $display("FAIL msb_sb: got sout=%b idx=%0d first=%b last=%b, want sout=%b idx=%0d first=%b last=%b",
                     sout_a, bit_idx_a, first_a, last_a, e.sout, e.idx, e.first, e.last);
          end
        end
      end
      if (c == 0) begin in_a = 16'hA5C3; in_valid_a = 1'b1; end
      else if (sent) in_valid_a = 1'b0;
      #1;
      if (in_valid_a && in_ready_a) begin push_a(in_a); sent = 1; end
    end
    tests++;
    if (nvalid != 16 || seen !== 16'b1010010111000011 || q_a.size() != 0) begin
      fails++;
      $display("FAIL msb_stream: got %0d bits %b (%0d left), want 16 bits 1010010111000011", nvalid, seen, q_a.size());
    end
    $display("[TB] test_msb_hold1 done");
  endtask

  task automatic test_lsb_hold3();
    exp_t e;
    int nbusy = 0, nhigh = 0, nvalid = 0;
    bit sent = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy_b) nbusy++;
      if (sout_valid_b) begin
        nvalid++;
        if (sout_b) nhigh++;
        tests++;
        if (q_b.size() == 0) begin
          fails++;
          $display("FAIL lsb_sb: unexpected bit sout=%b idx=%0d, want none", sout_b, bit_idx_b);
        end else begin
          e = q_b.pop_front();
          if ({sout_b, bit_idx_b, first_b, last_b} !== e) begin
            fails++;
            $display("FAIL lsb_sb: got sout=%b idx=%0d first=%b last=%b, want sout=%b idx=%0d first=%b last=%b",
                     sout_b, bit_idx_b, first_b, last_b, e.sout, e.idx, e.first, e.last);
          end
        end
      end else if (!busy_b) begin
        tests++;
        if ({sout_b, bit_idx_b, first_b, last_b} !== 7'd0) begin
          fails++;
          $display("FAIL lsb_idle_outputs: got %b, want 0000000", {sout_b, bit_idx_b, first_b, last_b});
        end
      end
      if (c == 0) begin in_b = 16'h0001; in_valid_b = 1'b1; end
      else if (sent) in_valid_b = 1'b0;
      #1;
      if (in_valid_b && in_ready_b) begin push_b(in_b); sent = 1; end
    end
    tests++;
    if (nbusy != 48 || nhigh != 3 || nvalid != 48 || q_b.size() != 0) begin
      fails++;
      $display("FAIL lsb_lengths: got busy=%0d high=%0d valid=%0d left=%0d, want 48 3 48 0", nbusy, nhigh, nvalid, q_b.size());
    end
    $display("[TB] test_lsb_hold3 done");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int acc = 0, nvalid = 0, first_c = -1, last_c = -1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (sout_valid_a) begin
        nvalid++;
        if (first_c < 0) first_c = c;
        last_c = c;
        tests++;
        if (in_ready_a !== last_a) begin
          fails++;
          $display("FAIL b2b_ready: got ready=%b at idx=%0d, want %b", in_ready_a, bit_idx_a, last_a);
        end
        tests++;
        if (q_a.size() == 0) begin
          fails++;
          $display("FAIL b2b_sb: unexpected bit sout=%b idx=%0d, want none", sout_a, bit_idx_a);
        end else begin
          e = q_a.pop_front();
          if ({sout_a, bit_idx_a, first_a, last_a} !== e) begin
            fails++;
            $display("FAIL b2b_sb: got sout=%b idx=%0d first=%b last=%b, want sout=%b idx=%0d first=%b last=%b",
                     sout_a, bit_idx_a, first_a, last_a, e.sout, e.idx, e.first, e.last);
          end
        end
      end
      if (c == 0) begin in_a = 16'hFFFF; in_valid_a = 1'b1; end
      else if (acc == 1) in_a = 16'h0000;
      else if (acc == 2) in_valid_a = 1'b0;
      #1;
      if (in_valid_a && in_ready_a) begin push_a(in_a); acc++; end
    end
    tests++;
    if (nvalid != 32 || last_c - first_c != 31 || acc != 2 || q_a.size() != 0) begin
      fails++;
      $display("FAIL b2b_continuous: got valid=%0d span=%0d words=%0d left=%0d, want 32 32 2 0",
               nvalid, last_c - first_c + 1, acc, q_a.size());
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_pause();
    exp_t e;
    int nvalid = 0, pause_left = 0;
    bit sent = 0, paused = 0;
    logic [15:0] w = 16'h3C5A;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!enable_a) begin
        tests++;
        if ({sout_valid_a, in_ready_a, busy_a, bit_idx_a, sout_a, first_a, last_a} !== {3'b001, 4'd7, w[7], 2'b00}) begin
          fails++;
          $display("FAIL pause_hold: got valid=%b ready=%b busy=%b idx=%0d sout=%b first=%b last=%b, want 0 0 1 7 %b 0 0",
                   sout_valid_a, in_ready_a, busy_a, bit_idx_a, sout_a, first_a, last_a, w[7]);
        end
        pause_left--;
        if (pause_left == 0) enable_a = 1'b1;
      end else if (sout_valid_a) begin
        nvalid++;
        tests++;
        if (q_a.size() == 0) begin
          fails++;
          $display("FAIL pause_sb: unexpected bit sout=%b idx=%0d, want none", sout_a, bit_idx_a);
        end else begin
          e = q_a.pop_front();
          if ({sout_a, bit_idx_a, first_a, last_a} !== e) begin
            fails++;
            $display("FAIL pause_sb: got sout=%b idx=%0d first=%b last=%b, want sout=%b idx=%0d first=%b last=%b",
                     sout_a, bit_idx_a, first_a, last_a, e.sout, e.idx, e.first, e.last);
          end
        end
        if (bit_idx_a == 4'd7 && !paused) begin
          paused = 1; pause_left = 5; enable_a = 1'b0;
        end
      end
      if (c == 0) begin in_a = w; in_valid_a = 1'b1; end
      else if (sent) in_valid_a = 1'b0;
      #1;
      if (in_valid_a && in_ready_a) begin push_a(in_a); sent = 1; end
    end
    tests++;
    if (!paused || nvalid != 16 || q_a.size() != 0) begin
      fails++;
      $display("FAIL pause_length: got paused=%b enabled_bits=%0d left=%0d, want 1 16 0", paused, nvalid, q_a.size());
    end
    $display("[TB] test_pause done");
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int nvalid = 0;
    bit sent = 0, hit = 0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      if (sout_valid_a) begin
        tests++;
        e = (q_a.size() != 0) ? q_a.pop_front() : 7'd0;
        if ({sout_a, bit_idx_a, first_a, last_a} !== e) begin
          fails++;
          $display("FAIL rmid_sb: got sout=%b idx=%0d first=%b last=%b, want sout=%b idx=%0d first=%b last=%b",
                   sout_a, bit_idx_a, first_a, last_a, e.sout, e.idx, e.first, e.last);
        end
        if (bit_idx_a == 4'd9) hit = 1;
      end
      if (!hit) begin
        if (c == 0) begin in_a = 16'h1234; in_valid_a = 1'b1; end
        else if (sent) in_valid_a = 1'b0;
        #1;
        if (in_valid_a && in_ready_a) begin push_a(in_a); sent = 1; end
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL rmid_reach_bit9: got no bit 9 within 30 cycles, want bit 9");
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sout_a, sout_valid_a, first_a, last_a, busy_a, bit_idx_a} !== 9'd0) begin
      fails++;
      $display("FAIL rmid_async_clear: got %b, want 000000000", {sout_a, sout_valid_a, first_a, last_a, busy_a, bit_idx_a});
    end
    q_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy_a, in_ready_a} !== 2'b01) begin
      fails++;
      $display("FAIL rmid_release: got busy=%b ready=%b, want 0 1", busy_a, in_ready_a);
    end
    sent = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (sout_valid_a) begin
        nvalid++;
        tests++;
        if (q_a.size() == 0) begin
          fails++;
          $display("FAIL rmid_next_sb: unexpected bit sout=%b idx=%0d, want none", sout_a, bit_idx_a);
        end else begin
          e = q_a.pop_front();
          if ({sout_a, bit_idx_a, first_a, last_a} !== e) begin
            fails++;
            $display("FAIL rmid_next_sb: got sout=%b idx=%0d first=%b last=%b, want sout=%b idx=%0d first=%b last=%b",
                     sout_a, bit_idx_a, first_a, last_a, e.sout, e.idx, e.first, e.last);
          end
        end
      end
      if (c == 0) begin in_a = 16'h8000; in_valid_a = 1'b1; end
      else if (sent) in_valid_a = 1'b0;
      #1;
      if (in_valid_a && in_ready_a) begin push_a(in_a); sent = 1; end
    end
    tests++;
    if (nvalid != 16 || q_a.size() != 0) begin
      fails++;
      $display("FAIL rmid_next_length: got %0d bits, %0d left, want 16 0", nvalid, q_a.size());
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    rst_n = 1'b0;
    in_a = 16'd0; in_b = 16'd0;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    enable_a = 1'b1; enable_b = 1'b1;
    test_reset();
    test_msb_hold1();
    test_lsb_hold3();
    test_back_to_back();
    test_pause();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_serializer16.md
WORD_SERIALIZER16 -- requirements
Module: word_serializer16

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1; 1 = bit 15 emitted first, 0 = bit 0 first.
REQ-002 SHALL have parameter HOLD, default 1, legal 1..16; clock cycles each bit is held on SOUT.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port nRESET, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port IN, input, 16, parallel word to serialize.
REQ-006 SHALL have port IN_VALID, input, 1, IN holds a word offered for transfer.
REQ-007 SHALL have port IN_READY, output, 1, block accepts IN this cycle.
REQ-008 SHALL have port ENABLE, input, 1, 0 = pause (freeze all state).
REQ-009 SHALL have port SOUT, output, 1, current serial bit.
REQ-010 SHALL have port SOUT_VALID, output, 1, SOUT carries a valid bit.
REQ-011 SHALL have port BIT_IDX, output, 4, index within the captured word of the bit on SOUT.
REQ-012 SHALL have port FIRST, output, 1, SOUT is the first bit of a word.
REQ-013 SHALL have port LAST, output, 1, SOUT is the last bit of a word.
REQ-014 SHALL have port BUSY, output, 1, a word is in flight (state SHIFT).

Function
REQ-015 SHALL implement a two-state FSM, IDLE and SHIFT; the word register is 16 bits, the bit counter 4 bits, and the hold counter sized for HOLD-1.
REQ-016 A transfer SHALL occur on a rising edge where IN_VALID=1, IN_READY=1 and ENABLE=1; IN is captured and the FSM enters SHIFT with bit count 0 and hold count 0.
REQ-017 IN_READY SHALL be combinational: 1 when ENABLE=1 and either the FSM is in IDLE or it is in SHIFT with bit count 15 and hold count HOLD-1; otherwise 0.
REQ-018 In SHIFT with ENABLE=1, SOUT_VALID SHALL be 1.
REQ-019 In SHIFT, BIT_IDX SHALL be 15-count when MSB_FIRST=1 and count when MSB_FIRST=0, and SOUT SHALL equal the captured word bit at that index.
REQ-020 FIRST SHALL be 1 when count=0; LAST SHALL be 1 when count=15; both SHALL be qualified by SOUT_VALID.
REQ-021 Each bit SHALL be held exactly HOLD enabled cycles; the hold counter increments each enabled cycle and, at HOLD-1, wraps to 0 and the bit count advances.
REQ-022 When count=15 and hold=HOLD-1 with ENABLE=1, the word SHALL complete: with a transfer in the same cycle the FSM stays in SHIFT with the new word and count 0 (no bubble); otherwise it returns to IDLE.
REQ-023 Latency: the first bit SHALL appear on SOUT in the cycle after the transfer edge; a word SHALL occupy exactly 16*HOLD enabled cycles.
REQ-024 When ENABLE=0: FSM, counters and word register SHALL hold; SOUT_VALID and IN_READY SHALL be 0; BUSY SHALL reflect the state; SOUT and BIT_IDX SHALL hold their values.
REQ-025 In IDLE: SOUT_VALID, FIRST and LAST SHALL be 0, SOUT SHALL be 0, and BIT_IDX SHALL be 0.
REQ-026 IN_VALID SHALL be ignored while IN_READY=0; IN may change freely when no transfer occurs.

Reset
REQ-027 While nRESET=0, asynchronously: FSM=IDLE, word register=0, counters=0, and SOUT, SOUT_VALID, FIRST, LAST, BUSY and BIT_IDX all 0.
REQ-028 Reset asserted mid-word SHALL abort the word without completing it; after release the block SHALL be in IDLE with IN_READY=ENABLE.
REQ-029 Reset release SHALL take effect on the next rising CLK; no transfer SHALL occur on an edge where nRESET=0.

Verification
REQ-030 MSB_FIRST=1, HOLD=1: send IN=16'hA5C3 -> SOUT over 16 cycles = 1010010111000011; BIT_IDX 15..0; FIRST on cycle 1, LAST on cycle 16.
REQ-031 MSB_FIRST=0, HOLD=3: send IN=16'h0001 -> SOUT=1 for 3 cycles, then 0 for 45 cycles; BUSY high for exactly 48 cycles.
REQ-032 Back-to-back: IN_VALID held high with 16'hFFFF then 16'h0000 -> 32 consecutive SOUT_VALID cycles; IN_READY high only on the LAST cycle; no gap between words.
REQ-033 ENABLE=0 for 5 cycles at bit 7 -> SOUT_VALID=0 during the pause, BIT_IDX holds, and the stream resumes at the same bit; total word length is 16 enabled cycles.
REQ-034 nRESET pulsed low at bit 9 of 16'h1234 -> all outputs 0 immediately; after release IN_READY=1 and the next word 16'h8000 serializes cleanly from FIRST.
